// File: rtl/sm_regdump_if.sv
// sm_regdump_if: valid/ready byte stream carrying the register dump frame.
interface sm_regdump_if;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    modport master(output txData, txValid, input txReady);
    modport slave(input txData, txValid, output txReady);
endinterface

// File: rtl/sm_regdump.sv
// sm_regdump: sweeps the CPU debug register port and streams A5 + NREGS big-endian words.
// Define SM_REGDUMP_CSUM_EN to append an XOR checksum byte over the data bytes.
module sm_regdump #(
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [4:0]    regAddr,
    input  logic [31:0]   regData,
    sm_regdump_if.master  tx
);
    typedef enum logic [2:0] {
        IDLE, HDR, LOAD, SEND
`ifdef SM_REGDUMP_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef SM_REGDUMP_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    logic        xfer;

    assign xfer       = tx_valid_q & tx.txReady;
    assign busy       = busy_q;
    assign done       = done_q;
    assign regAddr    = idx_q;
    assign tx.txData  = tx_data_q;
    assign tx.txValid = tx_valid_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef SM_REGDUMP_CSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d    = HDR;
                idx_d      = 5'd0;
                busy_d     = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = 8'hA5;
`ifdef SM_REGDUMP_CSUM_EN
                csum_d     = 8'h00;
`endif
            end
            HDR: if (xfer) begin
                state_d    = LOAD;
                tx_valid_d = 1'b0;
            end
            LOAD: begin
                state_d    = SEND;
                shift_d    = regData;
                cnt_d      = 2'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = regData[31:24];
            end
            SEND: if (xfer) begin
                shift_d   = {shift_q[23:0], 8'h00};
                cnt_d     = cnt_q + 2'd1;
                tx_data_d = shift_q[23:16];
`ifdef SM_REGDUMP_CSUM_EN
                csum_d    = csum_q ^ tx_data_q;
`endif
                if (cnt_q == 2'd3) begin
                    if (idx_q < 5'(NREGS - 1)) begin
                        state_d    = LOAD;
                        idx_d      = idx_q + 5'd1;
                        tx_valid_d = 1'b0;
                    end else begin
`ifdef SM_REGDUMP_CSUM_EN
                        state_d    = CSUM;
                        tx_data_d  = csum_q ^ tx_data_q;
`else
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
`endif
                    end
                end
            end
`ifdef SM_REGDUMP_CSUM_EN
            CSUM: if (xfer) begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 5'd0;
            cnt_q      <= 2'd0;
            shift_q    <= 32'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SM_REGDUMP_CSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SM_REGDUMP_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: directed checks of a 2-word and a 32-word dump engine sharing one clock/reset.
module tb_sm_regdump;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start2 = 1'b0, start32 = 1'b0;
    logic        rdy2 = 1'b1, rdy32 = 1'b1;
    logic        busy2, done2, busy32, done32;
    logic [4:0]  addr2, addr32;
    logic [31:0] data2, data32;
    logic        sel = 1'b0;
    logic        v, b, dn;
    logic [7:0]  d;
    logic [7:0]  got [0:199];
    int          nb, busy_n, stalls, total = 0, bad = 0;

    sm_regdump_if if2();
    sm_regdump_if if32();

    always #5 clk = ~clk;

    assign data2        = (addr2 == 5'd0) ? 32'h0040_0010 : 32'h1234_5678;
    assign data32       = {27'h0, addr32} * 32'h0101_0101;
    assign if2.txReady  = rdy2;
    assign if32.txReady = rdy32;
    assign v  = sel ? if32.txValid : if2.txValid;
    assign d  = sel ? if32.txData  : if2.txData;
    assign b  = sel ? busy32 : busy2;
    assign dn = sel ? done32 : done2;

    sm_regdump #(.NREGS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .regAddr(addr2), .regData(data2), .tx(if2)
    );
    sm_regdump #(.NREGS(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .busy(busy32), .done(done32),
        .regAddr(addr32), .regData(data32), .tx(if32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic s);
        if (sel) start32 = s; else start2 = s;
    endtask

    // Runs one frame on the selected DUT, recording accepted bytes, busy cycles and stalls.
    task automatic frame(input logic s32, input bit bp, input bit restart, input bit hold);
        logic pv, pr, rdy;
        logic [7:0] pd;
        bit ok;
        sel = s32; nb = 0; busy_n = 0; stalls = 0; ok = 0; pv = 0; pr = 0; pd = 0;
        @(negedge clk);
        set_start(1'b1);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) set_start(1'b0);
            if (restart && c == 4) set_start(1'b1);
            if (restart && c == 5) set_start(1'b0);
            rdy = bp ? c[0] : 1'b1;
            if (sel) rdy32 = rdy; else rdy2 = rdy;
            if (pv && !pr) begin
                chk("hold_valid", v, 1);
                chk("hold_data", d, pd);
            end
            if (b) busy_n++;
            if (v && !rdy) stalls++;
            if (v && rdy && nb < 200) begin got[nb] = d; nb++; end
            pv = v; pr = rdy; pd = d;
            if (dn) begin
                chk("busy_at_done", b, 0);
                ok = 1;
                break;
            end
        end
        if (!ok) chk("frame_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle", dn, 0);
        if (hold) begin
            chk("b2b_valid", v, 1);
            chk("b2b_hdr", d, 8'hA5);
            chk("b2b_busy", b, 1);
        end
    endtask

    task automatic chk_frame2(input string tag);
        logic [7:0] exp [0:9];
        exp = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h58};
`ifdef SM_REGDUMP_CSUM_EN
        chk({tag, "_nbytes"}, nb, 10);
        for (int i = 0; i < 10; i++) chk({tag, "_byte"}, got[i], exp[i]);
`else
        chk({tag, "_nbytes"}, nb, 9);
        for (int i = 0; i < 9; i++) chk({tag, "_byte"}, got[i], exp[i]);
`endif
    endtask

    initial begin
        #2;
        chk("rst_valid", if2.txValid, 0);
        chk("rst_data", if2.txData, 8'h00);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_valid", if2.txValid, 0);
            chk("idle_busy", busy2, 0);
            chk("idle_addr", addr2, 0);
            chk("idle_valid32", if32.txValid, 0);
        end

        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_frame2("basic");
`ifdef SM_REGDUMP_CSUM_EN
        chk("basic_busy", busy_n, 12);
`else
        chk("basic_busy", busy_n, 11);
`endif

        frame(1'b0, 1'b1, 1'b0, 1'b0);
        rdy2 = 1'b1;
        chk_frame2("bp");
        chk("bp_stalled", stalls > 0, 1);
`ifdef SM_REGDUMP_CSUM_EN
        chk("bp_busy", busy_n, 12 + stalls);
`else
        chk("bp_busy", busy_n, 11 + stalls);
`endif

        frame(1'b0, 1'b0, 1'b1, 1'b0);
        chk_frame2("restart");
        repeat (3) @(negedge clk);
        chk("restart_no_frame", if2.txValid, 0);

        frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk_frame2("hold1");
        start2 = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done2) begin seen = 1; break; end
            end
            chk("hold2_done", seen, 1);
        end
        @(negedge clk);
        chk("hold2_stop", if2.txValid, 0);

        sel = 1'b1;
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (addr32 == 5'd3 && if32.txValid) begin hit = 1; break; end
            end
            chk("reach_word3", hit, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", if32.txValid, 0);
        chk("arst_busy", busy32, 0);
        chk("arst_addr", addr32, 0);
        chk("arst_data", if32.txData, 8'h00);
        chk("arst_done", done32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", if32.txValid, 0);
        chk("post_rst_nodone", done32, 0);

        frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sweep_hdr", got[0], 8'hA5);
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 4; j++)
                chk("sweep_byte", got[1 + 4 * k + j], k);
`ifdef SM_REGDUMP_CSUM_EN
        chk("sweep_nbytes", nb, 130);
        chk("sweep_csum", got[129], 8'h00);
        chk("sweep_busy", busy_n, 162);
`else
        chk("sweep_nbytes", nb, 129);
        chk("sweep_busy", busy_n, 161);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
